cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter INDEX_WIDTH, default 3, SHALL set the line count to 1<<INDEX_WIDTH; tag width SHALL be ADDR_WIDTH-INDEX_WIDTH.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_op  input  Op  upstream request: Op_INVALID, Op_READ or Op_WRITE.
REQ-005 req_addr  input  ADDR_WIDTH  upstream word address.
REQ-006 req_data  input  DATA_WIDTH  upstream write data.
REQ-007 req_rdy  output  1  high when a request is accepted this cycle.
REQ-008 rsp_vld  output  1  one-cycle pulse marking read data valid.
REQ-009 rsp_data  output  DATA_WIDTH  read data.
REQ-010 mem_rst  output  1  synchronous, active-high reset to the downstream memory, equal to ~rst_n.
REQ-011 mem_req_op, mem_req_addr, mem_req_data  output  Op/ADDR_WIDTH/DATA_WIDTH  downstream memory request.
REQ-012 mem_rsp_vld, mem_rsp_data  input  1/DATA_WIDTH  downstream read response, arriving exactly one cycle after a READ is issued.

Function
REQ-013 The block SHALL be a direct-mapped, one-word-per-line, write-back, write-allocate cache with per-line valid, dirty, tag and data.
REQ-014 A request SHALL be accepted only in a cycle where req_op != Op_INVALID and req_rdy=1; req_rdy SHALL be 1 only in state READY.
REQ-015 States: READY, WRITEBACK, FILL, WAIT_FILL.
REQ-016 Read hit: rsp_vld=1 with line data in the cycle after acceptance; no memory traffic.
REQ-017 Write hit: line data=req_data and dirty=1 at the accepting edge; no response, no memory traffic.
REQ-018 On any miss the block SHALL latch op/addr/data; if the victim is valid and dirty, go to WRITEBACK, else go to FILL (read miss) or install directly (write miss).
REQ-019 WRITEBACK (one cycle): mem_req_op=Op_WRITE, addr={victim tag,index}, data=victim data; clear dirty; next FILL (read miss) or install-and-return READY (write miss).
REQ-020 Write-miss install: valid=1, tag=new tag, data=req_data, dirty=1; no memory read.
REQ-021 FILL (one cycle): mem_req_op=Op_READ, mem_req_addr=latched addr; next WAIT_FILL.
REQ-022 WAIT_FILL: on mem_rsp_vld, install valid=1, dirty=0, tag, data=mem_rsp_data; drive rsp_vld=1 and rsp_data=mem_rsp_data on the following cycle; return READY.
REQ-023 Latencies: clean read miss, rsp_vld 3 cycles after acceptance; dirty read miss, 4 cycles.
REQ-024 mem_req_op SHALL be Op_INVALID in every state except WRITEBACK and FILL; exactly one memory operation SHALL be issued per such state visit.
REQ-025 mem_rsp_vld outside WAIT_FILL SHALL be ignored.
REQ-026 rsp_vld SHALL never assert for write requests.

Reset
REQ-027 While rst_n=0: state=READY, all valid/dirty=0, rsp_vld=0, rsp_data=0, mem_req_op=Op_INVALID, mem_rst=1.
REQ-028 Reset mid-miss SHALL abandon the transaction with no response and no later install; tag/data arrays need not be cleared.

Structure
REQ-029 ADDR_WIDTH, DATA_WIDTH, Op enum, UbitAddr and UbitData SHALL come from cache_pkg; state enum local.
REQ-030 Optional sub-module cache_array (tag/data/valid/dirty storage with async read, sync write); the FSM stays in cache_ctrl.

Verification (ADDR_WIDTH=6, DATA_WIDTH=8, INDEX_WIDTH=3)
REQ-031 After reset, read 0x05 -> mem READ 0x05 in cycle +1; rsp_vld with rsp_data=0x00 at cycle +3.
REQ-032 Write 0x05=0xA5, then read 0x05 -> no memory traffic; rsp_data=0xA5 one cycle after acceptance.
REQ-033 Read 0x0D (same index) -> mem WRITE 0x05/0xA5, then READ 0x0D; rsp at +4; re-read 0x05 -> miss returns 0xA5.
REQ-034 Write miss 0x12=0x3C on an invalid line -> no memory traffic; read 0x12 hits with rsp_data=0x3C.
REQ-035 Hold req_op=Op_READ 0x20 during a miss with req_rdy=0 -> exactly one mem READ and one rsp_vld.
REQ-036 Drive rst_n low during WAIT_FILL -> no rsp_vld; after release req_rdy=1 and read 0x05 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, operation encoding and request payload for the cache controller.
// No ports; imported by the interface, the storage array and the controller.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH = 8;

  typedef logic [ADDR_WIDTH-1:0] UbitAddr;
  typedef logic [DATA_WIDTH-1:0] UbitData;

  typedef enum logic [1:0] {
    Op_INVALID = 2'd0,
    Op_READ    = 2'd1,
    Op_WRITE   = 2'd2
  } op_e;

  // Request captured on a miss and replayed while the miss is serviced.
  typedef struct packed {
    op_e     op;
    UbitAddr addr;
    UbitData data;
  } req_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// Upstream request/response bus and downstream memory bus of the cache controller.
// Signals: req_op/req_addr/req_data/req_rdy, rsp_vld/rsp_data (upstream);
//          mem_rst, mem_req_op/mem_req_addr/mem_req_data, mem_rsp_vld/mem_rsp_data (memory).
// master: the requester plus memory side; slave: the cache controller.
interface cache_ctrl_if;
  import cache_pkg::*;

  op_e     req_op;
  UbitAddr req_addr;
  UbitData req_data;
  logic    req_rdy;
  logic    rsp_vld;
  UbitData rsp_data;

  logic    mem_rst;
  op_e     mem_req_op;
  UbitAddr mem_req_addr;
  UbitData mem_req_data;
  logic    mem_rsp_vld;
  UbitData mem_rsp_data;

  modport master (
    output req_op, req_addr, req_data, mem_rsp_vld, mem_rsp_data,
    input  req_rdy, rsp_vld, rsp_data, mem_rst, mem_req_op, mem_req_addr, mem_req_data
  );

  modport slave (
    input  req_op, req_addr, req_data, mem_rsp_vld, mem_rsp_data,
    output req_rdy, rsp_vld, rsp_data, mem_rst, mem_req_op, mem_req_addr, mem_req_data
  );

endinterface

// File: rtl/cache_array.sv
// Direct-mapped line storage: valid/dirty bits (reset) and tag/data (no reset).
// Ports: clk, rst_n; rd_index -> rd_valid/rd_dirty/rd_tag/rd_data (async read);
//        wr_en/wr_index/wr_valid/wr_dirty/wr_tag/wr_data (sync write, one line per cycle).
module cache_array
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 3,
  parameter int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output UbitData                rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic                   wr_valid,
  input  logic                   wr_dirty,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  UbitData                wr_data
);

  localparam int unsigned LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  UbitData              data_q [LINES];

  // Line state bits: cleared by reset so every line starts invalid and clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= wr_valid;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // Tag/data payload: contents are don't-care while the line is invalid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-back, write-allocate cache controller.
// Ports: clk, rst_n (async, active-low); bus (cache_ctrl_if.slave) carrying the
//        upstream request/response and the downstream memory request/response.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_ctrl_if.slave  bus
);

  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

  typedef enum logic [1:0] {READY, WRITEBACK, FILL, WAIT_FILL} state_e;

  state_e  state_q, state_d;
  req_t    lat_q, lat_d;
  logic    req_rdy_q, req_rdy_d;
  logic    rsp_vld_q, rsp_vld_d;
  UbitData rsp_data_q, rsp_data_d;
  op_e     mem_op_q, mem_op_d;
  UbitAddr mem_addr_q, mem_addr_d;
  UbitData mem_data_q, mem_data_d;

  logic [INDEX_WIDTH-1:0] req_index, lat_index, rd_index, wr_index;
  logic [TAG_WIDTH-1:0]   req_tag, lat_tag, rd_tag, wr_tag;
  logic                   rd_valid, rd_dirty, wr_en, wr_dirty;
  UbitData                rd_data, wr_data;
  logic                   hit, victim_dirty;

  assign req_index = bus.req_addr[INDEX_WIDTH-1:0];
  assign req_tag   = bus.req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign lat_index = lat_q.addr[INDEX_WIDTH-1:0];
  assign lat_tag   = lat_q.addr[ADDR_WIDTH-1:INDEX_WIDTH];

  // Look up the incoming request while idle, the captured miss otherwise.
  assign rd_index     = (state_q == READY) ? req_index : lat_index;
  assign hit          = rd_valid && (rd_tag == req_tag);
  assign victim_dirty = rd_valid && rd_dirty;

  cache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_valid (1'b1),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  // Next state, next registered outputs and array write port.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    rsp_vld_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    mem_op_d   = Op_INVALID;
    mem_addr_d = '0;
    mem_data_d = '0;
    wr_en      = 1'b0;
    wr_index   = lat_index;
    wr_dirty   = 1'b0;
    wr_tag     = lat_tag;
    wr_data    = lat_q.data;

    case (state_q)
      READY: begin
        if (req_rdy_q && bus.req_op != Op_INVALID) begin
          if (bus.req_op == Op_READ && hit) begin
            rsp_vld_d  = 1'b1;
            rsp_data_d = rd_data;
          end else if (bus.req_op == Op_WRITE && (hit || !victim_dirty)) begin
            // Write hit, or write miss over a clean/invalid victim: install in place.
            wr_en    = 1'b1;
            wr_index = req_index;
            wr_dirty = 1'b1;
            wr_tag   = req_tag;
            wr_data  = bus.req_data;
          end else begin
            lat_d = '{op: bus.req_op, addr: bus.req_addr, data: bus.req_data};
            if (victim_dirty) begin
              state_d    = WRITEBACK;
              mem_op_d   = Op_WRITE;
              mem_addr_d = {rd_tag, req_index};
              mem_data_d = rd_data;
            end else begin
              state_d    = FILL;
              mem_op_d   = Op_READ;
              mem_addr_d = bus.req_addr;
            end
          end
        end
      end
      WRITEBACK: begin
        wr_en = 1'b1;
        if (lat_q.op == Op_READ) begin
          // Victim stays resident but clean until the fill replaces it.
          wr_tag     = rd_tag;
          wr_data    = rd_data;
          state_d    = FILL;
          mem_op_d   = Op_READ;
          mem_addr_d = lat_q.addr;
        end else begin
          wr_dirty = 1'b1;
          state_d  = READY;
        end
      end
      FILL: begin
        state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (bus.mem_rsp_vld) begin
          wr_en      = 1'b1;
          wr_data    = bus.mem_rsp_data;
          rsp_vld_d  = 1'b1;
          rsp_data_d = bus.mem_rsp_data;
          state_d    = READY;
        end
      end
      default: state_d = READY;
    endcase

    req_rdy_d = (state_d == READY);
  end

  // All state and outputs; reset abandons any miss in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= READY;
      lat_q      <= '0;
      req_rdy_q  <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      mem_op_q   <= Op_INVALID;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      req_rdy_q  <= req_rdy_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      mem_op_q   <= mem_op_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign bus.req_rdy      = req_rdy_q;
  assign bus.rsp_vld      = rsp_vld_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.mem_req_op   = mem_op_q;
  assign bus.mem_req_addr = mem_addr_q;
  assign bus.mem_req_data = mem_data_q;
  // Memory reset tracks the controller reset directly.
  assign bus.mem_rst      = ~rst_n;

endmodule
